// File: rtl/decode_execute_reg.sv
// Decode -> execute pipeline register with stall, flush, valid tracking
// and a saturating bubble counter for performance analysis.
module decode_execute_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              ValidD,
  input  logic [DATA_W-1:0] ExtImmD,
  input  logic [DATA_W-1:0] RD1D,
  input  logic [DATA_W-1:0] RD2D,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3D,
  input  logic [3:0]        CondD,
  input  logic [1:0]        ALUControlD,
  input  logic [1:0]        FlagWriteD,
  input  logic              ALUSrcD,
  input  logic              MemtoRegD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              PCSrcD,
  output logic              ValidE,
  output logic [DATA_W-1:0] ExtImmE,
  output logic [DATA_W-1:0] RD1E,
  output logic [DATA_W-1:0] RD2E,
  output logic [3:0]        RA1E,
  output logic [3:0]        RA2E,
  output logic [3:0]        WA3E,
  output logic [3:0]        CondE,
  output logic [1:0]        ALUControlE,
  output logic [1:0]        FlagWriteE,
  output logic              ALUSrcE,
  output logic              MemtoRegE,
  output logic              RegWriteE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              PCSrcE,
  output logic [CNT_W-1:0]  BubbleCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // A bubble enters E on a flush, or on a non-stalled load of an invalid slot
  logic w_bubble;
  assign w_bubble = FlushE | (~StallE & ~ValidD);

  // Pipeline fields: flush zeroes everything, stall holds, otherwise load.
  // Side-effecting controls are qualified by ValidD so an invalid slot is inert.
  always_ff @(posedge clk or posedge reset) begin
    if (reset || FlushE) begin
      ValidE      <= 1'b0;
      ExtImmE     <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      RA1E        <= '0;
      RA2E        <= '0;
      WA3E        <= '0;
      CondE       <= '0;
      ALUControlE <= '0;
      FlagWriteE  <= '0;
      ALUSrcE     <= 1'b0;
      MemtoRegE   <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      BranchE     <= 1'b0;
      PCSrcE      <= 1'b0;
    end else if (!StallE) begin
      ValidE      <= ValidD;
      ExtImmE     <= ExtImmD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      RA1E        <= RA1D;
      RA2E        <= RA2D;
      WA3E        <= WA3D;
      CondE       <= CondD;
      ALUControlE <= ALUControlD;
      FlagWriteE  <= FlagWriteD & {2{ValidD}};
      ALUSrcE     <= ALUSrcD;
      MemtoRegE   <= MemtoRegD;
      RegWriteE   <= RegWriteD & ValidD;
      MemWriteE   <= MemWriteD & ValidD;
      BranchE     <= BranchD & ValidD;
      PCSrcE      <= PCSrcD & ValidD;
    end
  end

  // Saturating bubble counter; only reset clears it
  logic [CNT_W-1:0] r_bubble_cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != CNT_MAX)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
    end
  end

  assign BubbleCount = r_bubble_cnt;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: a vector table, directed multi-cycle
// sequences and random traffic checked against a field-level model.
module tb_decode_execute_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  wa3;
    logic [3:0]  cond;
    logic [1:0]  aluc;
    logic [1:0]  fw;
    logic        alusrc;
    logic        memtoreg;
    logic        regw;
    logic        memw;
    logic        branch;
    logic        pcsrc;
  } bundle_t;

  typedef struct {
    logic    stall;
    logic    flush;
    bundle_t d;
    bundle_t exp;
    int      cnt;
  } vec_t;

  logic    clk;
  logic    reset;
  logic    StallE;
  logic    FlushE;
  bundle_t d;
  bundle_t e;
  bundle_t e4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  // outputs of the CNT_W=16 instance
  logic        a_valid, a_alusrc, a_memtoreg, a_regw, a_memw, a_branch, a_pcsrc;
  logic [31:0] a_imm, a_rd1, a_rd2;
  logic [3:0]  a_ra1, a_ra2, a_wa3, a_cond;
  logic [1:0]  a_aluc, a_fw;
  // outputs of the CNT_W=4 instance
  logic        b_valid, b_alusrc, b_memtoreg, b_regw, b_memw, b_branch, b_pcsrc;
  logic [31:0] b_imm, b_rd1, b_rd2;
  logic [3:0]  b_ra1, b_ra2, b_wa3, b_cond;
  logic [1:0]  b_aluc, b_fw;

  assign e  = '{a_valid, a_imm, a_rd1, a_rd2, a_ra1, a_ra2, a_wa3, a_cond, a_aluc, a_fw,
                a_alusrc, a_memtoreg, a_regw, a_memw, a_branch, a_pcsrc};
  assign e4 = '{b_valid, b_imm, b_rd1, b_rd2, b_ra1, b_ra2, b_wa3, b_cond, b_aluc, b_fw,
                b_alusrc, b_memtoreg, b_regw, b_memw, b_branch, b_pcsrc};

  decode_execute_reg #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(d.valid),
    .ExtImmD(d.imm), .RD1D(d.rd1), .RD2D(d.rd2), .RA1D(d.ra1), .RA2D(d.ra2),
    .WA3D(d.wa3), .CondD(d.cond), .ALUControlD(d.aluc), .FlagWriteD(d.fw),
    .ALUSrcD(d.alusrc), .MemtoRegD(d.memtoreg), .RegWriteD(d.regw),
    .MemWriteD(d.memw), .BranchD(d.branch), .PCSrcD(d.pcsrc),
    .ValidE(a_valid), .ExtImmE(a_imm), .RD1E(a_rd1), .RD2E(a_rd2), .RA1E(a_ra1),
    .RA2E(a_ra2), .WA3E(a_wa3), .CondE(a_cond), .ALUControlE(a_aluc),
    .FlagWriteE(a_fw), .ALUSrcE(a_alusrc), .MemtoRegE(a_memtoreg),
    .RegWriteE(a_regw), .MemWriteE(a_memw), .BranchE(a_branch), .PCSrcE(a_pcsrc),
    .BubbleCount(cnt)
  );

  decode_execute_reg #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .StallE(StallE), .FlushE(FlushE), .ValidD(d.valid),
    .ExtImmD(d.imm), .RD1D(d.rd1), .RD2D(d.rd2), .RA1D(d.ra1), .RA2D(d.ra2),
    .WA3D(d.wa3), .CondD(d.cond), .ALUControlD(d.aluc), .FlagWriteD(d.fw),
    .ALUSrcD(d.alusrc), .MemtoRegD(d.memtoreg), .RegWriteD(d.regw),
    .MemWriteD(d.memw), .BranchD(d.branch), .PCSrcD(d.pcsrc),
    .ValidE(b_valid), .ExtImmE(b_imm), .RD1E(b_rd1), .RD2E(b_rd2), .RA1E(b_ra1),
    .RA2E(b_ra2), .WA3E(b_wa3), .CondE(b_cond), .ALUControlE(b_aluc),
    .FlagWriteE(b_fw), .ALUSrcE(b_alusrc), .MemtoRegE(b_memtoreg),
    .RegWriteE(b_regw), .MemWriteE(b_memw), .BranchE(b_branch), .PCSrcE(b_pcsrc),
    .BubbleCount(cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // reference state
  bundle_t exp_e;
  int      exp_cnt;
  int      exp_cnt4;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic chk_all(input string tag);
    n_cmp++;
    if (e !== exp_e) begin
      n_mis++;
      $display("FAIL %s fields: got %h expected %h", tag, e, exp_e);
    end
    n_cmp++;
    if (e4 !== exp_e) begin
      n_mis++;
      $display("FAIL %s fields4: got %h expected %h", tag, e4, exp_e);
    end
    cmp({tag, " count"}, 64'(cnt), 64'(exp_cnt));
    cmp({tag, " count4"}, 64'(cnt4), 64'(exp_cnt4));
  endtask

  // E-stage contents after one edge, straight from the stall/flush/valid rules
  function automatic bundle_t model_next(bundle_t cur, bundle_t din, logic st, logic fl);
    bundle_t n;
    if (fl) n = '0;
    else if (st) n = cur;
    else begin
      n = din;
      if (!din.valid) begin
        n.regw = 1'b0; n.memw = 1'b0; n.branch = 1'b0; n.pcsrc = 1'b0; n.fw = 2'b00;
      end
    end
    return n;
  endfunction

  task automatic step(input logic st, input logic fl, input bundle_t din, input string tag);
    StallE = st;
    FlushE = fl;
    d      = din;
    @(posedge clk);
    exp_e = model_next(exp_e, din, st, fl);
    if ((fl || !st) && !exp_e.valid) begin
      if (exp_cnt < 65535) exp_cnt++;
      if (exp_cnt4 < 15) exp_cnt4++;
    end
    #1;
    chk_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    exp_e = '0; exp_cnt = 0; exp_cnt4 = 0;
    chk_all(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic bundle_t rand_bundle(input int valid_pct);
    bundle_t b;
    b = '0;
    b.valid    = ($urandom_range(99) < valid_pct);
    b.imm      = $urandom; b.rd1 = $urandom; b.rd2 = $urandom;
    b.ra1      = 4'($urandom); b.ra2 = 4'($urandom);
    b.wa3      = 4'($urandom); b.cond = 4'($urandom);
    b.aluc     = 2'($urandom); b.fw = 2'($urandom);
    b.alusrc   = 1'($urandom); b.memtoreg = 1'($urandom);
    b.regw     = 1'($urandom); b.memw = 1'($urandom);
    b.branch   = 1'($urandom); b.pcsrc = 1'($urandom);
    return b;
  endfunction

  vec_t    vec[6];
  bundle_t t;

  initial begin
    // vector table: expected E contents and bubble count after each edge
    t = '0; t.valid = 1; t.imm = 32'hFFFF_FFF8; t.rd1 = 32'h1234_5678; t.wa3 = 4'hE; t.memw = 1;
    vec[0] = '{1'b0, 1'b0, t, t, 0};
    t = '0; t.valid = 0; t.regw = 1; t.memw = 1; t.pcsrc = 1; t.imm = 32'h55;
    vec[1].stall = 0; vec[1].flush = 0; vec[1].d = t;
    vec[1].exp = '0; vec[1].exp.imm = 32'h55; vec[1].cnt = 1;
    t = '0; t.valid = 1; t.regw = 1; t.imm = 32'h0000_0FFF; t.rd2 = 32'hDEAD_BEEF;
    vec[2] = '{1'b1, 1'b1, t, '0, 2};
    t = '0; t.valid = 1; t.imm = 32'h123; t.regw = 1;
    vec[3] = '{1'b1, 1'b0, t, '0, 2};
    t = '0; t.valid = 1; t.fw = 2'b11; t.branch = 1; t.cond = 4'hA; t.aluc = 2'b10;
    t.ra1 = 4'h3; t.ra2 = 4'h7; t.alusrc = 1; t.memtoreg = 1; t.rd2 = 32'hCAFE_0001;
    vec[4] = '{1'b0, 1'b0, t, t, 2};
    vec[5].exp = t; vec[5].cnt = 2; vec[5].stall = 1; vec[5].flush = 0;
    t.imm = 32'h7777_7777; t.valid = 0; t.wa3 = 4'h1;
    vec[5].d = t;

    reset = 1'b1; StallE = 1'b0; FlushE = 1'b0; d = '0;
    exp_e = '0; exp_cnt = 0; exp_cnt4 = 0;
    #12;
    chk_all("reset_state");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      step(vec[i].stall, vec[i].flush, vec[i].d, "model");
      n_cmp++;
      if (e !== vec[i].exp) begin
        n_mis++;
        $display("FAIL table[%0d] fields: got %h expected %h", i, e, vec[i].exp);
      end
      cmp("table count", 64'(cnt), 64'(vec[i].cnt));
      cmp("table count4", 64'(cnt4), 64'(vec[i].cnt));
    end

    // asynchronous reset in the middle of a stall, then first capture
    t = rand_bundle(100); t.imm = 32'h0000_00AB; t.regw = 1;
    StallE = 1'b1; d = t;
    do_reset("reset_midstall");
    step(1'b0, 1'b0, t, "post_reset");
    cmp("post_reset imm", 64'(a_imm), 64'h0000_00AB);
    cmp("post_reset regw", 64'(a_regw), 64'd1);
    cmp("post_reset valid", 64'(a_valid), 64'd1);

    // three-cycle stall with changing inputs, then release
    step(1'b0, 1'b0, rand_bundle(50), "pre_stall");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, rand_bundle(50), "stall");
    t = rand_bundle(100);
    step(1'b0, 1'b0, t, "stall_release");
    cmp("stall_release rd1", 64'(a_rd1), 64'(t.rd1));

    // saturation of the 4-bit counter
    do_reset("reset_sat");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, rand_bundle(50), "flush_run");
    cmp("sat count4", 64'(cnt4), 64'd15);
    cmp("sat count16", 64'(cnt), 64'd20);
    step(1'b0, 1'b0, rand_bundle(100), "sat_valid_load");
    cmp("sat hold count4", 64'(cnt4), 64'd15);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(3) == 0), ($urandom_range(7) == 0), rand_bundle(75), "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
